fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have port Clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port Rst, input, 1 bit, a synchronous, active-low reset.
REQ-004 The block SHALL have port stall, input, 1 bit, a hazard-unit request to hold the IF/ID stage.
REQ-005 The block SHALL have ports redirect, input, 1 bit, and redirect_pc, input, 32 bits, the taken-branch/jump target from EX.
REQ-006 The block SHALL have ports imem_req, output, 1 bit, and imem_addr, output, 32 bits, the instruction-memory request.
REQ-007 The block SHALL have port imem_ready, input, 1 bit; the memory accepts the request in any cycle where imem_req and imem_ready are both 1.
REQ-008 The block SHALL have ports imem_rvalid, input, 1 bit, and imem_rdata, input, 32 bits, the memory response.
REQ-009 The block SHALL have ports if_pc, output, 32 bits; if_instr, output, 32 bits; if_pc4, output, 32 bits, the IF/ID stage-register data.
REQ-010 The block SHALL have ports ifid_write_enable, output, 1 bit, and ifid_flush, output, 1 bit, the IF/ID stage-register controls.

Function
REQ-011 The block SHALL implement an FSM with states IDLE, REQ, WAIT and HOLD, and SHALL allow at most one outstanding request.
- IDLE: one cycle after reset, then go to REQ.
- REQ: imem_req=1 and imem_addr=pc; on acceptance, pc <= pc+4 and go to WAIT.
- WAIT: wait for imem_rvalid.
- HOLD: an instruction is buffered while stall=1.
REQ-012 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0); redirect_pc[1:0] SHALL be forced to 2'b00.
REQ-013 On imem_rvalid in WAIT with stall=0, the block SHALL deliver the instruction in the same cycle: if_instr=imem_rdata, if_pc=address of that request, if_pc4=if_pc+4; then go to REQ.
REQ-014 On imem_rvalid in WAIT with stall=1, the block SHALL capture the response in an internal buffer and go to HOLD; in the first cycle with stall=0 it SHALL deliver the buffered instruction and go to REQ.
REQ-015 ifid_write_enable SHALL equal ~stall | redirect.
REQ-016 ifid_flush SHALL be 1 in any cycle with redirect=1, or with stall=0 and no delivery, so that a bubble is inserted.
REQ-017 redirect SHALL have priority over stall and over delivery; any instruction delivered or held in that cycle is discarded.
REQ-018 redirect in REQ (accepted or not) SHALL set pc <= redirect_pc and remain in REQ; the next request uses redirect_pc.
REQ-019 redirect in WAIT SHALL set pc <= redirect_pc and set a drop flag; the next imem_rvalid SHALL be discarded, the flag cleared, and the FSM SHALL go to REQ.
REQ-020 redirect and imem_rvalid in the same WAIT cycle SHALL discard that response, leave the drop flag clear, and go to REQ.
REQ-021 redirect in HOLD SHALL clear the buffer, load pc, and go to REQ.
REQ-022 if_pc, if_instr and if_pc4 SHALL be don't-care when ifid_write_enable=0 or ifid_flush=1.

Reset
REQ-023 With Rst=0 at a clock edge, the block SHALL load state=IDLE, pc=RESET_PC, drop flag=0, and buffer=0.
REQ-024 During reset, imem_req SHALL be 0, ifid_flush SHALL be 1, and ifid_write_enable SHALL be 1.
REQ-025 Reset mid-WAIT SHALL abandon the outstanding request; a response arriving after reset release while in IDLE SHALL be ignored.

Configuration
REQ-026 With macro FETCH_PERF_EN defined, the block SHALL add outputs stall_cycles and fetch_count, each 32 bits, both reset to 0.
- stall_cycles increments in cycles with stall=1.
- fetch_count increments on each delivery.
- Both counters saturate at 32'hFFFF_FFFF.
REQ-027 Without FETCH_PERF_EN, these ports and counters SHALL be absent, with no other behavioural change.

Structure
REQ-028 The FSM state encodings and the constant NOP=32'h0000_0013 SHALL live in the shared package fetch_pkg.
REQ-029 The counters SHALL be one sub-module, fetch_perf_cnt, instantiated only under FETCH_PERF_EN; all other logic SHALL be flat.

Verification
REQ-030 The bench SHALL cover: release reset, imem_ready=1, 1-cycle latency -> first request at 32'h0; if_pc sequence 0,4,8 delivered every 2 cycles; ifid_flush=1 in the gap cycles.
REQ-031 The bench SHALL cover: stall=1 for 3 cycles over a response for pc 32'h8 -> HOLD; ifid_write_enable=0 for 3 cycles; if_pc=32'h8 delivered in the cycle stall falls.
REQ-032 The bench SHALL cover: redirect to 32'h100 while in WAIT -> the old response is dropped; the next imem_addr=32'h100; no delivery of the old pc.
REQ-033 The bench SHALL cover: redirect and stall both asserted with imem_rvalid -> ifid_flush=1 and ifid_write_enable=1; the next request is at redirect_pc.
REQ-034 The bench SHALL cover: pc=32'hFFFF_FFFC accepted -> next imem_addr=32'h0; and redirect_pc=32'h103 -> imem_addr=32'h100.
REQ-035 The bench SHALL cover, with FETCH_PERF_EN: 5 stall cycles and 3 deliveries -> stall_cycles=5, fetch_count=3; reset mid-WAIT -> both counters 0 and imem_req=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: FSM state encoding, NOP constant and PC increment helper.
// No logic or storage of its own.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// Saturating fetch statistics: stall cycles and delivered instructions, visible one cycle after the event.
// No backpressure; both counters clear on synchronous reset. Only present with FETCH_PERF_EN.
module fetch_perf_cnt (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        stall,
  input  logic        fetch,
  output logic [31:0] stall_cycles,
  output logic [31:0] fetch_count
);

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      stall_cycles <= '0;
      fetch_count  <= '0;
    end else begin
      if (stall && (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
      if (fetch && (fetch_count != 32'hFFFF_FFFF))
        fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch with one outstanding request; delivers the response combinationally into IF/ID,
// or buffers it while stalled. Redirect overrides stall and delivery. Counters with FETCH_PERF_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc4,
  output logic        ifid_write_enable,
  output logic        ifid_flush
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] fetch_count
`endif
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic         drop_q, drop_d;
  logic [31:0]  buf_instr_q, buf_instr_d;

  logic         req;
  logic         deliver;
  logic [31:0]  dlv_instr;
  logic [31:0]  target;

  assign target = {redirect_pc[31:2], 2'b00};

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      req_pc_q    <= RESET_PC;
      drop_q      <= 1'b0;
      buf_instr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      drop_q      <= drop_d;
      buf_instr_q <= buf_instr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    drop_d      = drop_q;
    buf_instr_d = buf_instr_q;
    req         = 1'b0;
    deliver     = 1'b0;
    dlv_instr   = NOP;

    case (state_q)
      IDLE: state_d = REQ;

      REQ: begin
        // The request is withheld under redirect so a stale address is never accepted.
        req = ~redirect;
        if (redirect) begin
          pc_d = target;
        end else if (imem_ready) begin
          req_pc_d = pc_q;
          pc_d     = pc_plus4(pc_q);
          state_d  = WAIT;
        end
      end

      WAIT: begin
        if (redirect) begin
          pc_d   = target;
          // A response arriving with the redirect is already discarded, so nothing left to drop.
          drop_d = ~imem_rvalid;
          if (imem_rvalid)
            state_d = REQ;
        end else if (imem_rvalid) begin
          state_d = REQ;
          if (drop_q) begin
            drop_d = 1'b0;
          end else if (stall) begin
            buf_instr_d = imem_rdata;
            state_d     = HOLD;
          end else begin
            deliver   = 1'b1;
            dlv_instr = imem_rdata;
          end
        end
      end

      HOLD: begin
        if (redirect) begin
          pc_d        = target;
          buf_instr_d = '0;
          state_d     = REQ;
        end else if (!stall) begin
          deliver   = 1'b1;
          dlv_instr = buf_instr_q;
          state_d   = REQ;
        end
      end

      default: state_d = IDLE;
    endcase

    if (!Rst) begin
      req     = 1'b0;
      deliver = 1'b0;
    end
  end

  assign imem_req          = req;
  assign imem_addr         = pc_q;
  assign if_instr          = dlv_instr;
  assign if_pc             = req_pc_q;
  assign if_pc4            = pc_plus4(req_pc_q);
  assign ifid_write_enable = ~Rst | ~stall | redirect;
  assign ifid_flush        = ~Rst | redirect | (~stall & ~deliver);

`ifdef FETCH_PERF_EN
  fetch_perf_cnt u_perf (
    .Clk          (Clk),
    .Rst          (Rst),
    .stall        (stall),
    .fetch        (deliver),
    .stall_cycles (stall_cycles),
    .fetch_count  (fetch_count)
  );
`endif

endmodule
